sodor_mem_model_param: RTL and testbench

- Parametrised, self-contained successor to the Sodor fuzzing memory model.
- Serves one instruction fetch port and one data port from a unified word array of fixed depth.
- Words never written and never read before return reproducible pseudo-random contents from an internal LFSR, so no DPI calls are needed.
- Data port adds:
  - sized and sign/zero-extended loads;
  - byte-lane stores;
  - valid/ready request handshake;
  - configurable response latency;
  - error reporting for misaligned, out-of-range and illegal accesses.

---
 rtl/sodor_mem_model_param.sv | 228 ++++++++++++++++++++++
 tb/tb_sodor_mem_model_param.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sodor_mem_model_param.sv
// Unified instruction/data memory model with lazy LFSR fill, sized loads and stores,
// a valid/ready data port with fixed response latency, and access error reporting.
module sodor_mem_model_param #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned DMEM_LAT    = 1,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_req_valid,
  input  logic [31:0] imem_req_addr,
  output logic        imem_resp_valid,
  output logic [31:0] imem_resp_data,
  input  logic        dmem_req_valid,
  output logic        dmem_req_ready,
  input  logic [31:0] dmem_req_addr,
  input  logic [31:0] dmem_req_data,
  input  logic        dmem_req_write_en,
  input  logic [2:0]  dmem_req_typ,
  output logic        dmem_resp_valid,
  output logic [31:0] dmem_resp_data,
  output logic        dmem_resp_err
);

  localparam int unsigned AddrW    = $clog2(DEPTH_WORDS);
  localparam int unsigned Lat      = (DMEM_LAT < 1) ? 1 : ((DMEM_LAT > 4) ? 4 : DMEM_LAT);
  localparam int unsigned Last     = Lat - 1;
  localparam logic [31:0] Seed     = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  localparam logic [2:0] MtB  = 3'd1;
  localparam logic [2:0] MtH  = 3'd2;
  localparam logic [2:0] MtW  = 3'd3;
  localparam logic [2:0] MtBu = 3'd5;
  localparam logic [2:0] MtHu = 3'd6;
  localparam logic [2:0] MtWu = 3'd7;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? LfsrTaps : 32'h0);
  endfunction

  // Storage and state
  logic [31:0]            mem_q [DEPTH_WORDS];
  logic [DEPTH_WORDS-1:0] init_q, init_d;
  logic [31:0]            lfsr_q, lfsr_d;
  logic                   ready_q;
  logic                   imem_valid_q;
  logic [31:0]            imem_data_q;

  logic [Lat-1:0]         pipe_valid_q;
  logic [Lat-1:0]         pipe_err_q;
  logic [31:0]            pipe_data_q [Lat];

  // Address decode
  logic [AddrW-1:0] i_idx;
  logic [AddrW-1:0] d_idx;
  logic             d_in_range;
  logic             same_word;
  logic             unused_imem_bits;

  assign i_idx            = imem_req_addr[AddrW+1:2];
  assign d_idx            = dmem_req_addr[AddrW+1:2];
  assign d_in_range       = (dmem_req_addr[31:AddrW+2] == '0);
  assign same_word        = (i_idx == d_idx);
  // The fetch port ignores byte offset and wraps its upper bits.
  assign unused_imem_bits = ^{imem_req_addr[31:AddrW+2], imem_req_addr[1:0]};

  // Request classification
  logic d_err;
  logic d_acc;
  logic d_go;
  logic d_store;
  logic d_load;

  always_comb begin
    d_err = 1'b0;
    case (dmem_req_typ)
      MtB, MtBu: d_err = 1'b0;
      MtH, MtHu: d_err = dmem_req_addr[0];
      MtW, MtWu: d_err = |dmem_req_addr[1:0];
      default:   d_err = 1'b1;
    endcase
    if (!d_in_range) begin
      d_err = 1'b1;
    end
  end

  assign d_acc   = dmem_req_valid & ready_q;
  assign d_go    = d_acc & ~d_err;
  assign d_store = d_go & dmem_req_write_en;
  assign d_load  = d_go & ~dmem_req_write_en;

  // Lazy fill: an untouched word takes the current LFSR value on first access.
  logic        i_fill;
  logic        d_fill;
  logic [31:0] d_fill_val;

  assign i_fill = imem_req_valid & ~init_q[i_idx];
  assign d_fill = d_go & ~init_q[d_idx];

  always_comb begin
    d_fill_val = lfsr_q;
    lfsr_d     = lfsr_q;
    if (i_fill && d_fill && !same_word) begin
      d_fill_val = lfsr_step(lfsr_q);
      lfsr_d     = lfsr_step(lfsr_step(lfsr_q));
    end else if (i_fill || d_fill) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_comb begin
    init_d = init_q;
    if (i_fill) begin
      init_d[i_idx] = 1'b1;
    end
    if (d_fill) begin
      init_d[d_idx] = 1'b1;
    end
  end

  // Current word contents as seen by each port this cycle
  logic [31:0] i_word;
  logic [31:0] d_word;

  assign i_word = i_fill ? lfsr_q : mem_q[i_idx];
  assign d_word = d_fill ? d_fill_val : mem_q[d_idx];

  // Load extraction
  logic [31:0] d_shifted;
  logic [31:0] ld_data;

  assign d_shifted = d_word >> {dmem_req_addr[1:0], 3'b000};

  always_comb begin
    ld_data = d_word;
    case (dmem_req_typ)
      MtB:     ld_data = {{24{d_shifted[7]}}, d_shifted[7:0]};
      MtBu:    ld_data = {24'h0, d_shifted[7:0]};
      MtH:     ld_data = {{16{d_shifted[15]}}, d_shifted[15:0]};
      MtHu:    ld_data = {16'h0, d_shifted[15:0]};
      default: ld_data = d_word;
    endcase
  end

  // Store merge over the (possibly freshly filled) word
  logic [3:0]  st_mask;
  logic [31:0] st_wdata;
  logic [31:0] st_word;

  always_comb begin
    st_mask  = 4'hF;
    st_wdata = dmem_req_data;
    case (dmem_req_typ)
      MtB, MtBu: begin
        st_mask  = 4'b0001 << dmem_req_addr[1:0];
        st_wdata = {4{dmem_req_data[7:0]}};
      end
      MtH, MtHu: begin
        st_mask  = 4'b0011 << dmem_req_addr[1:0];
        st_wdata = {2{dmem_req_data[15:0]}};
      end
      default: begin
        st_mask  = 4'hF;
        st_wdata = dmem_req_data;
      end
    endcase
    for (int b = 0; b < 4; b++) begin
      st_word[8*b +: 8] = st_mask[b] ? st_wdata[8*b +: 8] : d_word[8*b +: 8];
    end
  end

  // Word array: no reset, validity is tracked by init_q
  always_ff @(posedge clk) begin
    if (i_fill && !(d_fill && same_word)) begin
      mem_q[i_idx] <= lfsr_q;
    end
    if (d_store) begin
      mem_q[d_idx] <= st_word;
    end else if (d_fill) begin
      mem_q[d_idx] <= d_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q       <= '0;
      lfsr_q       <= Seed;
      ready_q      <= 1'b0;
      imem_valid_q <= 1'b0;
      imem_data_q  <= 32'h0;
    end else begin
      init_q       <= init_d;
      lfsr_q       <= lfsr_d;
      ready_q      <= 1'b1;
      imem_valid_q <= imem_req_valid;
      imem_data_q  <= imem_req_valid ? i_word : 32'h0;
    end
  end

  // Response pipeline: stage 0 captures at accept, the rest only delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_q <= '0;
      pipe_err_q   <= '0;
      for (int s = 0; s < Lat; s++) begin
        pipe_data_q[s] <= 32'h0;
      end
    end else begin
      pipe_valid_q[0] <= d_acc;
      pipe_err_q[0]   <= d_acc & d_err;
      pipe_data_q[0]  <= d_load ? ld_data : 32'h0;
      for (int s = 1; s < Lat; s++) begin
        pipe_valid_q[s] <= pipe_valid_q[s-1];
        pipe_err_q[s]   <= pipe_err_q[s-1];
        pipe_data_q[s]  <= pipe_data_q[s-1];
      end
    end
  end

  assign dmem_req_ready  = ready_q;
  assign imem_resp_valid = imem_valid_q;
  assign imem_resp_data  = imem_data_q;
  assign dmem_resp_valid = pipe_valid_q[Last];
  assign dmem_resp_err   = pipe_err_q[Last];
  assign dmem_resp_data  = pipe_data_q[Last];

endmodule

// File: tb/tb_sodor_mem_model_param.sv
// Bench for sodor_mem_model_param: two instances (latency 1 and 3) share stimulus and are
// checked against a word-array reference model plus fixed vectors.
module tb_sodor_mem_model_param;

  localparam int unsigned Depth = 256;
  localparam logic [31:0] Seed  = 32'hACE1_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        i_v;
  logic [31:0] i_a;
  logic        d_v;
  logic        d_we;
  logic [31:0] d_a;
  logic [31:0] d_wd;
  logic [2:0]  d_typ;

  logic        o_iv  [2];
  logic [31:0] o_id  [2];
  logic        o_rdy [2];
  logic        o_dv  [2];
  logic [31:0] o_dd  [2];
  logic        o_de  [2];

  sodor_mem_model_param #(
    .DEPTH_WORDS(Depth), .DMEM_LAT(1), .LFSR_SEED(Seed)
  ) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(i_v), .imem_req_addr(i_a),
    .imem_resp_valid(o_iv[0]), .imem_resp_data(o_id[0]),
    .dmem_req_valid(d_v), .dmem_req_ready(o_rdy[0]), .dmem_req_addr(d_a),
    .dmem_req_data(d_wd), .dmem_req_write_en(d_we), .dmem_req_typ(d_typ),
    .dmem_resp_valid(o_dv[0]), .dmem_resp_data(o_dd[0]), .dmem_resp_err(o_de[0])
  );

  sodor_mem_model_param #(
    .DEPTH_WORDS(Depth), .DMEM_LAT(3), .LFSR_SEED(Seed)
  ) u_dut_l3 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(i_v), .imem_req_addr(i_a),
    .imem_resp_valid(o_iv[1]), .imem_resp_data(o_id[1]),
    .dmem_req_valid(d_v), .dmem_req_ready(o_rdy[1]), .dmem_req_addr(d_a),
    .dmem_req_data(d_wd), .dmem_req_write_en(d_we), .dmem_req_typ(d_typ),
    .dmem_resp_valid(o_dv[1]), .dmem_resp_data(o_dd[1]), .dmem_resp_err(o_de[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_mem  [Depth];
  bit          m_init [Depth];
  logic [31:0] m_lfsr;
  bit          m_ready;
  bit          sb_v [2][8];
  logic [31:0] sb_d [2][8];
  bit          sb_e [2][8];
  bit          exp_iv;
  logic [31:0] exp_id;
  int          edge_n = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic fill(input int w);
    m_mem[w]  = m_lfsr;
    m_init[w] = 1'b1;
    m_lfsr    = step(m_lfsr);
  endtask

  task automatic model_reset();
    foreach (m_init[w]) m_init[w] = 1'b0;
    m_lfsr  = Seed;
    m_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 8; s++) begin
        sb_v[k][s] = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    int          ii, di, sz, slot;
    bit          acc, err, inr;
    logic [1:0]  lo;
    logic [31:0] sh, res;
    ii  = int'((i_a >> 2) % Depth);
    acc = d_v && m_ready;
    inr = (d_a >> 2) < Depth;
    di  = inr ? int'(d_a >> 2) : 0;
    lo  = d_a[1:0];
    case (d_typ)
      3'd1, 3'd5: begin err = 1'b0;      sz = 1; end
      3'd2, 3'd6: begin err = lo[0];     sz = 2; end
      3'd3, 3'd7: begin err = (lo != 0); sz = 4; end
      default:    begin err = 1'b1;      sz = 4; end
    endcase
    if (!inr) err = 1'b1;
    // Fetch fills first, so a distinct data word gets the following LFSR value.
    if (i_v && !m_init[ii]) fill(ii);
    if (acc && !err && !m_init[di]) fill(di);
    exp_iv = i_v;
    exp_id = m_mem[ii];
    res    = 32'h0;
    if (acc && !err) begin
      if (!d_we) begin
        sh = m_mem[di] >> (8 * lo);
        case (d_typ)
          3'd1: begin res = sh & 32'hFF;   if (res >= 128)   res = res - 256;   end
          3'd5: res = sh & 32'hFF;
          3'd2: begin res = sh & 32'hFFFF; if (res >= 32768) res = res - 65536; end
          3'd6: res = sh & 32'hFFFF;
          default: res = m_mem[di];
        endcase
      end else begin
        for (int b = 0; b < sz; b++) begin
          m_mem[di][8*(lo+b) +: 8] = d_wd[8*b +: 8];
        end
      end
    end
    if (acc) begin
      for (int k = 0; k < 2; k++) begin
        slot          = (edge_n + lat_of(k) - 1) % 8;
        sb_v[k][slot] = 1'b1;
        sb_d[k][slot] = res;
        sb_e[k][slot] = err;
      end
    end
    m_ready = 1'b1;
  endtask

  task automatic cycle();
    int slot;
    @(posedge clk);
    model_edge();
    #1;
    slot = edge_n % 8;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("imem_valid%0d", k), o_iv[k], exp_iv);
      if (exp_iv) chk($sformatf("imem_data%0d", k), o_id[k], exp_id);
      chk($sformatf("ready%0d", k), o_rdy[k], 1);
      chk($sformatf("resp_valid%0d", k), o_dv[k], sb_v[k][slot]);
      if (sb_v[k][slot]) begin
        chk($sformatf("resp_data%0d", k), o_dd[k], sb_d[k][slot]);
        chk($sformatf("resp_err%0d", k), o_de[k], sb_e[k][slot]);
      end
      sb_v[k][slot] = 1'b0;
    end
    edge_n++;
  endtask

  task automatic do_reset();
    i_v   = 1'b0;
    d_v   = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", o_rdy[k], 0);
      chk("rst_dvalid", o_dv[k], 0);
      chk("rst_ddata", o_dd[k], 0);
      chk("rst_derr", o_de[k], 0);
      chk("rst_ivalid", o_iv[k], 0);
      chk("rst_idata", o_id[k], 0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk("rst_ready_held", o_rdy[k], 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic dreq(input bit we, input logic [2:0] typ, input logic [31:0] a,
                      input logic [31:0] wd);
    d_v = 1'b1; d_we = we; d_typ = typ; d_a = a; d_wd = wd;
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_d;
    bit          exp_e;
    bit          fetch;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int cnt;
    rst_n = 1'b1; i_v = 1'b0; i_a = '0; d_v = 1'b0; d_we = 1'b0; d_a = '0; d_wd = '0;
    d_typ = 3'd3;

    tbl.push_back('{1'b1, 3'd3, 32'h100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 3'd1, 32'h103, 32'h0,         32'hFFFF_FFDE, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 3'd5, 32'h103, 32'h0,         32'h0000_00DE, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h102, 32'h0,         32'hFFFF_DEAD, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 3'd6, 32'h102, 32'h0,         32'h0000_DEAD, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 3'd1, 32'h101, 32'hAAAA_AA55, 32'h0000_0000, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 3'd3, 32'h100, 32'h0,         32'hDEAD_55EF, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 3'd3, 32'h102, 32'h0,         32'h0000_0000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 3'd2, 32'h105, 32'h1111_1111, 32'h0000_0000, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 3'd4, 32'h100, 32'h0,         32'h0000_0000, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 3'd3, 4*Depth, 32'h0,         32'h0000_0000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 3'd0, 32'h100, 32'h0,         32'h0000_0000, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 3'd3, 32'h100, 32'h0,         32'hDEAD_55EF, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 3'd6, 32'h102, 32'hFFFF_1234, 32'h0000_0000, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 3'd7, 32'h100, 32'h0,         32'h1234_55EF, 1'b0, 1'b0});

    #2;
    do_reset();
    cycle();

    foreach (tbl[i]) begin
      dreq(tbl[i].we, tbl[i].typ, tbl[i].addr, tbl[i].wd);
      cycle();
      d_v = 1'b0;
      chk($sformatf("vec%0d_l1_valid", i), o_dv[0], 1);
      chk($sformatf("vec%0d_l1_data", i), o_dd[0], tbl[i].exp_d);
      chk($sformatf("vec%0d_l1_err", i), o_de[0], tbl[i].exp_e);
      i_v = tbl[i].fetch; i_a = tbl[i].addr;
      cycle();
      if (tbl[i].fetch) chk($sformatf("vec%0d_fetch", i), o_id[0], tbl[i].exp_d);
      i_v = 1'b0;
      cycle();
      chk($sformatf("vec%0d_l3_valid", i), o_dv[1], 1);
      chk($sformatf("vec%0d_l3_data", i), o_dd[1], tbl[i].exp_d);
      chk($sformatf("vec%0d_l3_err", i), o_de[1], tbl[i].exp_e);
    end

    // Fetch wraps modulo depth; a same-cycle store is not visible to the fetch
    i_v = 1'b1; i_a = 32'h100 + 4 * Depth;
    cycle();
    chk("fetch_wrap", o_id[0], 32'h1234_55EF);
    i_a = 32'h100;
    dreq(1'b1, 3'd3, 32'h100, 32'hCAFE_F00D);
    cycle();
    chk("fetch_old_data", o_id[0], 32'h1234_55EF);
    i_v = 1'b0;
    dreq(1'b0, 3'd3, 32'h100, 32'h0);
    cycle();
    d_v = 1'b0;
    chk("load_after_store", o_dd[0], 32'hCAFE_F00D);
    repeat (3) cycle();

    // Latency-3 back-to-back loads: four responses, in order, ready held high
    cnt = 0;
    for (int n = 0; n < 7; n++) begin
      if (n < 4) dreq(1'b0, 3'd3, 32'h100 + 4 * n, 32'h0);
      else d_v = 1'b0;
      cycle();
      cnt += int'(o_dv[1]);
    end
    chk("lat3_count", cnt, 4);

    // Reset with two loads in flight drops them and forgets memory contents
    dreq(1'b0, 3'd3, 32'h100, 32'h0);
    cycle();
    dreq(1'b0, 3'd3, 32'h104, 32'h0);
    cycle();
    do_reset();
    repeat (5) cycle();
    dreq(1'b0, 3'd3, 32'h100, 32'h0);
    cycle();
    d_v = 1'b0;
    chk("post_reset_seed", o_dd[0], Seed);
    repeat (3) cycle();

    // Fill order from reset
    do_reset();
    cycle();
    dreq(1'b0, 3'd3, 32'h200, 32'h0);
    cycle();
    chk("fill_first", o_dd[0], Seed);
    cycle();
    chk("fill_repeat", o_dd[0], Seed);
    d_v = 1'b0; i_v = 1'b1; i_a = 32'h200;
    cycle();
    chk("fill_fetch", o_id[0], Seed);
    i_v = 1'b0;
    dreq(1'b0, 3'd3, 32'h204, 32'h0);
    cycle();
    chk("fill_second", o_dd[0], 32'hD650_8003);
    d_v = 1'b0;
    repeat (3) cycle();

    // Simultaneous fills: distinct words, then one shared word
    do_reset();
    cycle();
    i_v = 1'b1; i_a = 32'h000;
    dreq(1'b0, 3'd3, 32'h004, 32'h0);
    cycle();
    chk("dual_fill_imem", o_id[0], Seed);
    chk("dual_fill_dmem", o_dd[0], 32'hD650_8003);
    i_a = 32'h010;
    dreq(1'b0, 3'd3, 32'h010, 32'h0);
    cycle();
    chk("same_fill_imem", o_id[0], 32'hEB08_4002);
    chk("same_fill_dmem", o_dd[0], 32'hEB08_4002);
    i_v = 1'b0; d_v = 1'b0;
    repeat (3) cycle();

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end
      i_v   = $urandom_range(0, 1) == 1;
      i_a   = $urandom_range(0, 32'h7FF);
      d_v   = $urandom_range(0, 3) != 0;
      d_we  = $urandom_range(0, 1) == 1;
      d_typ = 3'($urandom_range(0, 7));
      d_a   = $urandom_range(0, 32'h47F);
      if ($urandom_range(0, 3) != 0) d_a[1:0] = 2'b00;
      d_wd  = $urandom;
      cycle();
    end
    i_v = 1'b0; d_v = 1'b0;
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
